// File: rtl/kmap_input_sequencer.sv
// Input stage for the 3-input K-map consumer: synchronises and debounces board inputs and steps
// X,Y,Z through all 8 combinations. Define SEQ_GRAY_EN to walk the combinations in Gray order.
module kmap_input_sequencer #(
    parameter int DWELL_CYC = 12_000_000,
    parameter int DB_CYC    = 120_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       btn_step,
    input  logic       sw_x,
    input  logic       sw_y,
    input  logic       sw_z,
    output logic       X,
    output logic       Y,
    output logic       Z,
    output logic [2:0] idx,
    output logic       step_p,
    output logic       wrap_p
);

    localparam int DWW = $clog2(DWELL_CYC);
    localparam int DBW = $clog2(DB_CYC + 1);

    typedef enum logic [1:0] {
        ST_MAN    = 2'b00,
        ST_AUTO   = 2'b01,
        ST_PASS   = 2'b10,
        ST_FREEZE = 2'b11
    } state_t;

    logic           btn_s1, btn_s2;
    logic [2:0]     sw_s1, sw_s2;
    logic [DBW-1:0] db_cnt;
    logic           db_level, db_level_d;
    logic [DWW-1:0] dwell_cnt;
    logic [DWW-1:0] dwell_base;
    state_t         state, prev_state;
    logic           step_req, entering_auto, dwell_done, advance;
    logic [2:0]     next_idx;

    function automatic logic [2:0] seq_map(input logic [2:0] i);
`ifdef SEQ_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1     <= 1'b0;
            btn_s2     <= 1'b0;
            sw_s1      <= 3'b000;
            sw_s2      <= 3'b000;
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
        end else begin
            btn_s1     <= btn_step;
            btn_s2     <= btn_s1;
            sw_s1      <= {sw_x, sw_y, sw_z};
            sw_s2      <= sw_s1;
            db_level_d <= db_level;
            // A level is accepted only after DB_CYC consecutive mismatching samples.
            if (btn_s2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DB_CYC - 1)) begin
                db_level <= btn_s2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
        end
    end

    // Mode is a slow board setting and is decoded directly without synchronisation.
    assign state         = state_t'(mode);
    assign step_req      = db_level & ~db_level_d;
    assign entering_auto = (state == ST_AUTO) && (prev_state != ST_AUTO);
    assign dwell_base    = entering_auto ? '0 : dwell_cnt;
    assign dwell_done    = (dwell_base == DWW'(DWELL_CYC - 1));
    assign next_idx      = idx + 3'd1;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        advance = 1'b0;
        case (state)
            ST_MAN:  advance = step_req;
            ST_AUTO: advance = step_req || dwell_done;
            default: advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_state <= ST_MAN;
            idx        <= 3'd0;
            {X, Y, Z}  <= 3'b000;
            step_p     <= 1'b0;
            wrap_p     <= 1'b0;
            dwell_cnt  <= '0;
        end else begin
            prev_state <= state;
            step_p     <= advance;
            wrap_p     <= advance && (idx == 3'd7);
            if (advance) begin
                idx <= next_idx;
            end
            // Outputs follow the post-advance index on the same edge.
            case (state)
                ST_MAN: begin
                    {X, Y, Z} <= seq_map(advance ? next_idx : idx);
                end
                ST_AUTO: begin
                    {X, Y, Z} <= seq_map(advance ? next_idx : idx);
                    dwell_cnt <= advance ? '0 : dwell_base + DWW'(1);
                end
                ST_PASS: begin
                    {X, Y, Z} <= sw_s2;
                end
                default: begin
                    // Freeze: index, outputs and dwell count all hold.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmap_input_sequencer.sv
// Self-checking bench for kmap_input_sequencer: directed scenarios plus randomized stimulus
// compared against a cycle-level behavioural model of the sequencer's rules.
module tb_kmap_input_sequencer;

    localparam int DWELL = 4;
    localparam int DB    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       btn_step, sw_x, sw_y, sw_z;
    logic       X, Y, Z;
    logic [2:0] idx;
    logic       step_p, wrap_p;

    int n_checks = 0;
    int n_errors = 0;

    kmap_input_sequencer #(.DWELL_CYC(DWELL), .DB_CYC(DB)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .btn_step(btn_step),
        .sw_x(sw_x), .sw_y(sw_y), .sw_z(sw_z),
        .X(X), .Y(Y), .Z(Z), .idx(idx), .step_p(step_p), .wrap_p(wrap_p)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_map(input int i);
        logic [2:0] b;
        b = 3'(i % 8);
`ifdef SEQ_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // ---------------- behavioural reference model ----------------
    bit         m_b1, m_b2, m_level, m_level_prev;
    logic [2:0] m_sw1, m_sw2, m_xyz;
    int         m_run, m_dwell, m_idx;
    bit         m_step, m_wrap;
    logic [1:0] m_prev_mode;

    always @(posedge clk) begin
        bit req, adv;
        if (!rst_n) begin
            m_b1 = 0; m_b2 = 0; m_level = 0; m_level_prev = 0;
            m_sw1 = 0; m_sw2 = 0; m_xyz = 0;
            m_run = 0; m_dwell = 0; m_idx = 0;
            m_step = 0; m_wrap = 0; m_prev_mode = 2'd0;
        end else begin
            req = m_level && !m_level_prev;
            adv = 0;
            m_step = 0;
            m_wrap = 0;
            case (mode)
                2'd0: adv = req;
                2'd1: begin
                    if (m_prev_mode != 2'd1) m_dwell = 0;
                    adv = req || (m_dwell == DWELL - 1);
                    m_dwell = adv ? 0 : m_dwell + 1;
                end
                2'd2: m_xyz = m_sw2;
                default: ;
            endcase
            if (adv) begin
                m_wrap = (m_idx == 7);
                m_idx  = (m_idx + 1) % 8;
                m_step = 1;
            end
            if (mode == 2'd0 || mode == 2'd1) m_xyz = exp_map(m_idx);
            m_prev_mode = mode;
            m_level_prev = m_level;
            if (m_b2 != m_level) begin
                m_run++;
                if (m_run == DB) begin
                    m_level = m_b2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_b2 = m_b1;
            m_b1 = btn_step;
            m_sw2 = m_sw1;
            m_sw1 = {sw_x, sw_y, sw_z};
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mode = 2'd0; btn_step = 1'b0; {sw_x, sw_y, sw_z} = 3'b000;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int steps;
        rst_n = 1'b0;
        mode = 2'($urandom_range(0, 3));
        btn_step = 1'($urandom);
        {sw_x, sw_y, sw_z} = 3'($urandom);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({idx, X, Y, Z, step_p, wrap_p} !== 8'd0) begin
                n_errors++;
                $display("FAIL reset_hold: idx=%0d xyz=%b%b%b step=%b wrap=%b, expected all zero",
                         idx, X, Y, Z, step_p, wrap_p);
            end
        end
        rst_n = 1'b1; mode = 2'd0; btn_step = 1'b0; {sw_x, sw_y, sw_z} = 3'b000;
        tick();
        n_checks++;
        if ({idx, X, Y, Z, step_p, wrap_p} !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_release: idx=%0d xyz=%b%b%b step=%b, expected 0/000/0",
                     idx, X, Y, Z, step_p);
        end
        // Button held through reset: exactly one request once released.
        rst_n = 1'b0; btn_step = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        steps = 0;
        repeat (10) begin tick(); steps += int'(step_p); end
        btn_step = 1'b0;
        repeat (8) begin tick(); steps += int'(step_p); end
        n_checks++;
        if (steps !== 1 || idx !== 3'd1) begin
            n_errors++;
            $display("FAIL held_through_reset: steps=%0d idx=%0d, expected 1 step idx=1", steps, idx);
        end
    endtask

    task automatic test_manual();
        int steps, wraps;
        do_reset();
        steps = 0; wraps = 0;
        btn_step = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            steps += int'(step_p); wraps += int'(wrap_p);
            if (e == 5) begin
                n_checks++;
                if (idx !== 3'd0 || step_p !== 1'b0) begin
                    n_errors++;
                    $display("FAIL manual_early: idx=%0d step=%b at edge 5, expected 0/0", idx, step_p);
                end
            end
            if (e == 6) begin
                n_checks++;
                if (idx !== 3'd1 || step_p !== 1'b1 || {X, Y, Z} !== exp_map(1)) begin
                    n_errors++;
                    $display("FAIL manual_latency: idx=%0d step=%b xyz=%b at edge 6, expected 1/1/%b",
                             idx, step_p, {X, Y, Z}, exp_map(1));
                end
            end
        end
        btn_step = 1'b0;
        repeat (7) begin tick(); steps += int'(step_p); wraps += int'(wrap_p); end
        for (int p = 0; p < 7; p++) begin
            btn_step = 1'b1;
            repeat (8) begin tick(); steps += int'(step_p); wraps += int'(wrap_p); end
            btn_step = 1'b0;
            repeat (7) begin tick(); steps += int'(step_p); wraps += int'(wrap_p); end
        end
        n_checks++;
        if (steps !== 8 || wraps !== 1 || idx !== 3'd0 || {X, Y, Z} !== exp_map(0)) begin
            n_errors++;
            $display("FAIL manual_wrap: steps=%0d wraps=%0d idx=%0d xyz=%b, expected 8/1/0/%b",
                     steps, wraps, idx, {X, Y, Z}, exp_map(0));
        end
    endtask

    task automatic test_bounce();
        int steps;
        steps = 0;
        for (int i = 0; i < 8; i++) begin
            btn_step = (i % 2 == 0);
            tick();
            steps += int'(step_p);
        end
        btn_step = 1'b1;
        repeat (12) begin tick(); steps += int'(step_p); end
        btn_step = 1'b0;
        repeat (8) begin tick(); steps += int'(step_p); end
        n_checks++;
        if (steps !== 1 || idx !== 3'd1) begin
            n_errors++;
            $display("FAIL bounce: steps=%0d idx=%0d, expected 1 step idx=1", steps, idx);
        end
    endtask

    task automatic test_auto();
        bit exp_step;
        int k;
        do_reset();
        mode = 2'd1;
        for (int j = 1; j <= 33; j++) begin
            tick();
            exp_step = (j % 4 == 0);
            k = j / 4;
            n_checks++;
            if (step_p !== exp_step || (exp_step && (idx !== 3'(k % 8) || {X, Y, Z} !== exp_map(k)
                || wrap_p !== (k == 8))) || (!exp_step && wrap_p !== 1'b0)) begin
                n_errors++;
                $display("FAIL auto_cycle%0d: step=%b wrap=%b idx=%0d xyz=%b, expected step=%b idx=%0d",
                         j, step_p, wrap_p, idx, {X, Y, Z}, exp_step, k % 8);
            end
        end
        // Press mid-dwell: auto step at 36, button step at 39, dwell restarts -> next at 43.
        btn_step = 1'b1;
        for (int j = 34; j <= 44; j++) begin
            tick();
            exp_step = (j == 36 || j == 39 || j == 43);
            n_checks++;
            if (step_p !== exp_step) begin
                n_errors++;
                $display("FAIL auto_restart_cycle%0d: step=%b expected %b", j, step_p, exp_step);
            end
        end
        btn_step = 1'b0;
        mode = 2'd0;
        repeat (8) tick();
        n_checks++;
        if (idx !== 3'd3) begin
            n_errors++;
            $display("FAIL auto_total: idx=%0d expected 3", idx);
        end
    endtask

    task automatic test_passthrough_freeze();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            btn_step = 1'b1; repeat (8) tick();
            btn_step = 1'b0; repeat (7) tick();
        end
        n_checks++;
        if (idx !== 3'd3) begin
            n_errors++;
            $display("FAIL pass_setup: idx=%0d expected 3", idx);
        end
        mode = 2'd2;
        {sw_x, sw_y, sw_z} = 3'b101;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_checks++;
            if (idx !== 3'd3 || step_p !== 1'b0 || {X, Y, Z} !== ((e < 3) ? 3'b000 : 3'b101)) begin
                n_errors++;
                $display("FAIL pass_latency_edge%0d: idx=%0d step=%b xyz=%b", e, idx, step_p, {X, Y, Z});
            end
        end
        for (int m = 2; m <= 3; m++) begin
            mode = 2'(m);
            if (m == 3) {sw_x, sw_y, sw_z} = 3'b010;
            for (int c = 0; c < 15; c++) begin
                btn_step = (c < 8);
                tick();
                n_checks++;
                if (idx !== 3'd3 || step_p !== 1'b0 || wrap_p !== 1'b0 || {X, Y, Z} !== 3'b101) begin
                    n_errors++;
                    $display("FAIL hold_mode%0d_c%0d: idx=%0d step=%b xyz=%b, expected 3/0/101",
                             m, c, idx, step_p, {X, Y, Z});
                end
            end
        end
        mode = 2'd0;
        tick();
        n_checks++;
        if (idx !== 3'd3 || step_p !== 1'b0 || {X, Y, Z} !== exp_map(3)) begin
            n_errors++;
            $display("FAIL restore_map: idx=%0d xyz=%b, expected 3/%b", idx, {X, Y, Z}, exp_map(3));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 15) == 0) sw_x = ~sw_x;
            if ($urandom_range(0, 15) == 0) sw_y = ~sw_y;
            if ($urandom_range(0, 15) == 0) sw_z = ~sw_z;
            tick();
            n_checks++;
            if (idx !== 3'(m_idx) || {X, Y, Z} !== m_xyz || step_p !== m_step || wrap_p !== m_wrap) begin
                n_errors++;
                $display("FAIL random_c%0d: idx=%0d xyz=%b step=%b wrap=%b, model idx=%0d xyz=%b step=%b wrap=%b",
                         c, idx, {X, Y, Z}, step_p, wrap_p, m_idx, m_xyz, m_step, m_wrap);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'd0; btn_step = 1'b0;
        sw_x = 1'b0; sw_y = 1'b0; sw_z = 1'b0;
        test_reset();
        test_manual();
        test_bounce();
        test_auto();
        test_passthrough_freeze();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
